// File: rtl/uart_loader.sv
// Program-load framer fed by the UART receiver byte stream.
// Parses SYNC, 16-bit length, payload and XOR checksum; writes payload to memory.
module uart_loader #(
  parameter int         ADDR_WIDTH     = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1040000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_done,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [1:0]            err_code,
  output logic [15:0]           prog_len
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_LEN  = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [16:0]           cnt_q, cnt_d;
  logic [7:0]            csum_q, csum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic [15:0]           plen_q, plen_d;
  logic [16:0]           len_full;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;
    plen_d      = plen_q;
    len_full    = {1'b0, len_q[15:8], rx_data};

    if (state_q == IDLE || rx_done) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (rx_done && rx_data == SYNC_BYTE) begin
          state_d = LEN_HI;
          busy_d  = 1'b1;
          code_d  = 2'b00;
        end
      end
      LEN_HI: begin
        if (rx_done) begin
          len_d[15:8] = rx_data;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (rx_done) begin
          len_d[7:0] = rx_data;
          cnt_d      = '0;
          csum_d     = '0;
          if (len_full > MAX_LEN) begin
            err_d   = 1'b1;
            code_d  = 2'b10;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (len_full == '0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rx_done) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_WIDTH-1:0];
          mem_wdata_d = rx_data;
          csum_d      = csum_q ^ rx_data;
          cnt_d       = cnt_q + 17'd1;
          if (cnt_d == {1'b0, len_q}) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (rx_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (rx_data == csum_q) begin
            done_d = 1'b1;
            plen_d = len_q;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b01;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte arriving in the expiry cycle takes precedence over the timeout
    if (state_q != IDLE && !rx_done && tmo_q == TMO_LAST) begin
      err_d   = 1'b1;
      code_d  = 2'b11;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= '0;
      plen_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
      plen_q      <= plen_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign err_code  = code_q;
  assign prog_len  = plen_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: frame table plus timeout and reset sequences.
// Writes and end-of-frame events are scoreboarded against queued expectations.
module tb_uart_loader;

  localparam int AW  = 4;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          load_done;
  logic          load_err;
  logic [1:0]    err_code;
  logic [15:0]   prog_len;

  uart_loader #(
    .ADDR_WIDTH    (AW),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .load_done(load_done),
    .load_err (load_err),
    .err_code (err_code),
    .prog_len (prog_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int last_rx = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  typedef struct {
    logic        done;
    logic        err;
    logic [1:0]  code;
    logic [15:0] plen;
    logic        busy;
    int          cyc;
  } ev_t;

  typedef struct {
    logic [23:0][7:0] b;
    int               n;
    int               ofs;
    int               nwr;
    logic             done;
    logic [1:0]       code;
    logic [15:0]      plen;
  } fr_t;

  wr_t wq[$];
  ev_t evq[$];
  wr_t w_pop;
  ev_t ev_mon;
  fr_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                   mem_addr, mem_wdata);
        end else begin
          w_pop = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w_pop.a));
          chk("wr_data", 32'(mem_wdata), 32'(w_pop.d));
        end
      end
      if (load_done || load_err) begin
        ev_mon.done = load_done;
        ev_mon.err  = load_err;
        ev_mon.code = err_code;
        ev_mon.plen = prog_len;
        ev_mon.busy = busy;
        ev_mon.cyc  = cyc;
        evq.push_back(ev_mon);
      end
    end
  end

  task automatic mk(input int i, input logic [63:0] v, input int n,
                    input int ofs, input int nwr, input logic done,
                    input logic [1:0] code, input logic [15:0] plen);
    for (int k = 0; k < 24; k++) begin
      tbl[i].b[k] = (k < 8) ? v[63-8*k -: 8] : 8'h00;
    end
    tbl[i].n    = n;
    tbl[i].ofs  = ofs;
    tbl[i].nwr  = nwr;
    tbl[i].done = done;
    tbl[i].code = code;
    tbl[i].plen = plen;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit burst);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    last_rx = cyc;
    rx_done = 1'b0;
    if (!burst) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_load_done"}, 32'(load_done), 0);
    chk({tag, "_load_err"}, 32'(load_err), 0);
    chk({tag, "_err_code"}, 32'(err_code), 0);
    chk({tag, "_prog_len"}, 32'(prog_len), 0);
  endtask

  task automatic run_frame(input int i, input bit burst);
    ev_t  ev;
    wr_t  w;
    for (int k = 0; k < tbl[i].nwr; k++) begin
      w.a = AW'(k);
      w.d = tbl[i].b[tbl[i].ofs+k];
      wq.push_back(w);
    end
    evq.delete();
    for (int k = 0; k < tbl[i].n; k++) begin
      send_byte(tbl[i].b[k], burst);
    end
    repeat (3) @(negedge clk);
    chk($sformatf("f%0d_writes_left", i), 32'(wq.size()), 0);
    wq.delete();
    chk($sformatf("f%0d_events", i), 32'(evq.size()), 1);
    if (evq.size() > 0) begin
      ev = evq.pop_front();
      chk($sformatf("f%0d_done", i), 32'(ev.done), 32'(tbl[i].done));
      chk($sformatf("f%0d_err", i), 32'(ev.err), 32'(!tbl[i].done));
      chk($sformatf("f%0d_code", i), 32'(ev.code), 32'(tbl[i].code));
      chk($sformatf("f%0d_plen", i), 32'(ev.plen), 32'(tbl[i].plen));
      chk($sformatf("f%0d_busy", i), 32'(ev.busy), 0);
      chk($sformatf("f%0d_latency", i), 32'(ev.cyc - last_rx), 0);
    end
    chk($sformatf("f%0d_pulse_end", i), 32'({load_done, load_err}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    ev_t        ev;
    wr_t        w;
    logic [7:0] cs;

    mk(0, 64'hA5_00_03_11_22_33_00_00, 7, 3, 3, 1'b1, 2'b00, 16'd3);
    mk(1, 64'hA5_00_02_0F_F0_00_00_00, 6, 3, 2, 1'b0, 2'b01, 16'd3);
    mk(2, 64'h7E_A5_00_00_00_00_00_00, 5, 4, 0, 1'b1, 2'b00, 16'd0);
    mk(3, 64'hA5_00_11_00_00_00_00_00, 3, 3, 0, 1'b0, 2'b10, 16'd0);
    mk(4, 64'hA5_00_10_00_00_00_00_00, 20, 3, 16, 1'b1, 2'b00, 16'd16);
    cs = 8'h00;
    for (int k = 0; k < 16; k++) begin
      tbl[4].b[3+k] = 8'(k * 37 + 5);
      cs ^= tbl[4].b[3+k];
    end
    tbl[4].b[19] = cs;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_frame(i, 1'b0);
    end

    w.a = '0;
    w.d = 8'hAA;
    wq.push_back(w);
    evq.delete();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0);
    chk("tmo_busy_before", 32'(busy), 1);
    for (int k = 0; k < 300 && evq.size() == 0; k++) @(negedge clk);
    chk("tmo_writes_left", 32'(wq.size()), 0);
    wq.delete();
    if (evq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tmo_wait: got no event expected load_err");
    end else begin
      ev = evq.pop_front();
      chk("tmo_err", 32'(ev.err), 1);
      chk("tmo_done", 32'(ev.done), 0);
      chk("tmo_code", 32'(ev.code), 3);
      chk("tmo_busy", 32'(ev.busy), 0);
      chk("tmo_delay", 32'(ev.cyc - last_rx), TMO);
    end

    run_frame(0, 1'b1);

    w.a = AW'(0);
    w.d = 8'h11;
    wq.push_back(w);
    w.a = AW'(1);
    w.d = 8'h22;
    wq.push_back(w);
    evq.delete();
    send_byte(8'hA5, 1'b0);
    chk("rst_busy_sync", 32'(busy), 1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("rst_plen_before", 32'(prog_len), 3);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    chk("rst_writes_left", 32'(wq.size()), 0);
    chk("rst_events", 32'(evq.size()), 0);
    wq.delete();
    @(negedge clk);

    run_frame(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
